// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 device-to-host deframer, E0/F0 prefix folding, ctrl/shift tracking, event FIFO.
// Latency: an event reaches the FIFO head 2 CLK cycles after the synchronised KEY_CLK fall that samples the stop bit.
// Backpressure: none toward the keyboard; an event arriving while the FIFO is full is dropped and sets sticky overflow.
// Build option: define PS2_PARITY_CHECK_EN to enforce odd parity and add the sticky parity_err port.
module ps2_key_receiver #(
  parameter logic [15:0] TIMEOUT         = 16'd2000,
  parameter int          FIFO_DEPTH_LOG2 = 2
) (
  input  logic       CLK,
  input  logic       XRST,
  input  logic       KEY_CLK,
  input  logic       KEY_DATA,
  input  logic       rd,
  output logic [7:0] event_code,
  output logic       event_ext,
  output logic       event_brk,
  output logic       empty,
  output logic       overflow,
  output logic       ctrl,
  output logic       shift
`ifdef PS2_PARITY_CHECK_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  logic [1:0]  kclk_sync;
  logic [1:0]  kdat_sync;
  logic        kclk_prev;
  logic        fe;
  logic        kdat;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;      // {stop, parity, data[7:0]} once the frame is complete
  logic [15:0] wd_cnt;
  logic        ext_pending;
  logic        brk_pending;

  logic [7:0]  rx_byte;
  logic        parity_ok;
  logic        frame_ok;
  logic        emit;

  logic [9:0]               ram [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2:0] rd_ptr;
  logic                     full;
  logic                     do_rd;
  logic                     do_wr;

  // Two-flop synchronisers for both PS/2 lines plus a delayed clock copy for edge detection
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      kclk_sync <= 2'b11;
      kdat_sync <= 2'b11;
      kclk_prev <= 1'b1;
    end else begin
      kclk_sync <= {kclk_sync[0], KEY_CLK};
      kdat_sync <= {kdat_sync[0], KEY_DATA};
      kclk_prev <= kclk_sync[1];
    end
  end

  assign fe   = kclk_prev & ~kclk_sync[1];
  assign kdat = kdat_sync[1];

  assign rx_byte   = shreg[7:0];
  assign parity_ok = ^shreg[8:0];
`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok  = shreg[9] & parity_ok;
`else
  assign frame_ok  = shreg[9];
`endif
  assign emit = (state == CHECK) && frame_ok && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

  // Frame FSM with watchdog, prefix folding and modifier tracking (prefix flags survive dropped frames)
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      wd_cnt      <= '0;
      ext_pending <= 1'b0;
      brk_pending <= 1'b0;
      ctrl        <= 1'b0;
      shift       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fe && !kdat) begin
            state   <= RECV;
            bit_cnt <= '0;
            wd_cnt  <= '0;
          end
        end
        RECV: begin
          if (fe) begin
            shreg  <= {kdat, shreg[9:1]};
            wd_cnt <= '0;
            if (bit_cnt == 4'd9) state <= CHECK;
            else bit_cnt <= bit_cnt + 4'd1;
          end else if (wd_cnt >= TIMEOUT) begin
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (frame_ok) begin
            if (rx_byte == 8'hE0) begin
              ext_pending <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
              brk_pending <= 1'b1;
            end else begin
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
              if (rx_byte == 8'h14) ctrl <= !brk_pending;
              if ((rx_byte == 8'h12 || rx_byte == 8'h59) && !ext_pending) shift <= !brk_pending;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // Sticky parity error, raised whenever a completed frame fails odd parity
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) parity_err <= 1'b0;
    else if (state == CHECK && !parity_ok) parity_err <= 1'b1;
  end
`endif

  // FIFO status: extra pointer MSB distinguishes full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {FIFO_DEPTH_LOG2{1'b0}}});
  assign do_rd = rd & ~empty;
  assign do_wr = emit & (~full | do_rd);

  // FIFO pointers and sticky overflow; a simultaneous pop frees the slot for a write when full
  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (emit && !do_wr) overflow <= 1'b1;
    end
  end

  // Event storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge CLK) begin
    if (do_wr) ram[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {ext_pending, brk_pending, rx_byte};
  end

  assign {event_ext, event_brk, event_code} = ram[rd_ptr[FIFO_DEPTH_LOG2-1:0]];

endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
PS/2 keyboard front end inside top. Consumes raw KEY_CLK/KEY_DATA, deframes 11-bit device-to-host frames and folds E0/F0 prefixes into one key event. Tracks ctrl/shift modifier state and buffers events in a small FIFO that the core's I/O unit pops.

Parameters:
TIMEOUT, 16'd2000, CLK cycles without a KEY_CLK falling edge before a partial frame is discarded
FIFO_DEPTH_LOG2, 2, event FIFO depth = 2**FIFO_DEPTH_LOG2 entries

Ports:
CLK  input  1  system clock
XRST  input  1  asynchronous active-low reset
KEY_CLK  input  1  PS/2 clock from keyboard, asynchronous, idle high
KEY_DATA  input  1  PS/2 data from keyboard, asynchronous
rd  input  1  pop head event; ignored when empty
event_code  output  8  head scan code, without prefixes
event_ext  output  1  head event was E0-prefixed
event_brk  output  1  head event was F0-prefixed (release)
empty  output  1  FIFO empty
overflow  output  1  sticky; event dropped while FIFO full
ctrl  output  1  a ctrl key is held (make 14 / E0 14 set, break clears)
shift  output  1  a shift key is held (make 12 or 59 set, break clears)

Behaviour:
- Reset is asynchronous on XRST low. All state clears: FIFO empty, empty=1, overflow=0, ctrl=0, shift=0, prefix flags 0, frame FSM IDLE, synchronisers 1.
- KEY_CLK and KEY_DATA each pass through 2-flop synchronisers. A falling edge is synchronised-clock 1 then 0, giving a single-cycle pulse fe.
- Frame FSM is IDLE -> RECV -> CHECK.
  - IDLE: on fe with data 0 (start bit), go to RECV with bit count 0. On fe with data 1, stay in IDLE.
  - RECV: each fe shifts data in LSB first. Count 0-7 are data, 8 is parity, 9 is stop. After the stop bit, go to CHECK.
  - CHECK: lasts one cycle, then returns to IDLE. The frame is accepted if stop is 1 (and parity is valid, see Optional Feature). Otherwise it is silently dropped.
- Watchdog counts cycles since the last fe while in RECV. When it reaches TIMEOUT, return to IDLE and drop the frame. The counter reloads on every fe.
- Decoding an accepted byte B:
  - B=E0: set ext_pending; no event.
  - B=F0: set brk_pending; no event.
  - Otherwise: emit event {ext_pending, brk_pending, B}, then clear both pending flags.
- Modifiers update in the same cycle as the emit:
  - ctrl <= !brk when B=14, with or without ext.
  - shift <= !brk when B=12 or 59, ext=0.
- Latency: an event is visible at the FIFO head (empty=0) 2 cycles after the fe that sampled the stop bit.
- FIFO:
  - Write pointer and read pointer are FIFO_DEPTH_LOG2+1 bits wide and wrap naturally. full = pointers differ only in MSB.
  - Emit while full: the event is dropped and overflow is set. overflow clears only on reset.
  - rd while empty: no effect.
  - Emit and rd in the same cycle: both take effect, so occupancy is unchanged even when full.
  - Head outputs are combinational from the RAM at the read pointer and valid only while empty=0.
- Pending prefix flags survive timeouts and dropped frames. They clear only on emit or reset.
- XRST asserted mid-frame aborts the frame. Bits already shifted are discarded.

Optional Feature:
PS2_PARITY_CHECK_EN.
- Defined: CHECK requires the XOR of the 8 data bits and the parity bit to be 1 (odd parity). On failure the frame is dropped and an extra output port parity_err (1 bit, sticky, reset 0) is set.
- Undefined: the parity bit is shifted but ignored, and the parity_err port does not exist.

Test Plan:
- Frame for 0x1C (A) with correct parity and stop -> one event: code=1C, ext=0, brk=0; empty falls 2 cycles after the stop fe; rd -> empty=1.
- Bytes 14, F0, 14 -> event 14/brk=0 with ctrl=1, then event 14/brk=1 with ctrl=0; exactly 2 events, no event for F0.
- Bytes E0, F0, 75 -> single event code=75, ext=1, brk=1; a following 1C -> ext=0, brk=0.
- 5 events with no rd at depth 4 -> overflow=1; pops return the first 4 codes in order; then empty=1.
- Start bit plus 4 bits, then idle for TIMEOUT+5 cycles, then a full 0x29 frame -> single event 29. Also pulse XRST mid-frame -> all outputs at reset values.
- With PS2_PARITY_CHECK_EN: 0x1C with even parity -> no event, parity_err=1. Without the macro: the same frame is accepted as 1C.
